fifo_burst_ctrl: RTL and testbench

FIFO_BURST_CTRL -- requirements
Module: fifo_burst_ctrl

---
 rtl/fifo_ctrl_pkg.sv | 20 ++
 rtl/fifo_burst_ctrl_burst_counter.sv | 28 ++
 rtl/fifo_burst_ctrl.sv | 130 +++++++++++++
 tb/tb_fifo_burst_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared types and default constants for the FIFO burst controller.
package fifo_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DONE  = 2'd3
   } burst_state_t;

   localparam int DEF_CNT_W     = 13;
   localparam int DEF_LEN_SMALL = 1056;
   localparam int DEF_LEN_LARGE = 6144;

   // A single channel still needs a 1-bit select port.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_burst_ctrl_burst_counter.sv
// Write-index counter with synchronous clear, beat enable and terminal compare.
module burst_counter
   import fifo_ctrl_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             enable,
   input  logic [CNT_W-1:0] last,
   output logic [CNT_W-1:0] count,
   output logic             at_last
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= '0;
      else if (enable)
         count <= count + 1'b1;
   end

   // last is len-1, so the compare never depends on the counter wrapping.
   assign at_last = (count == last);

endmodule

// File: rtl/fifo_burst_ctrl.sv
// Burst write controller driving one of NUM_CH FIFOs with len consecutive beats.
// Optional sticky protocol-error flag built only with FIFO_BURST_CTRL_ERR_EN.
module fifo_burst_ctrl
   import fifo_ctrl_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int CNT_W     = DEF_CNT_W,
   parameter int LEN_SMALL = DEF_LEN_SMALL,
   parameter int LEN_LARGE = DEF_LEN_LARGE
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           start,
   input  logic                           mode,
   input  logic [sel_width(NUM_CH)-1:0]   ch_sel,
   input  logic                           stall,
   input  logic                           abort,
   output logic [NUM_CH-1:0]              we,
   output logic [CNT_W-1:0]               addr,
   output logic                           busy,
   output logic                           done,
   output logic                           err
);

   localparam int CH_W = sel_width(NUM_CH);
   localparam logic [CNT_W-1:0] LAST_SMALL = CNT_W'(LEN_SMALL - 1);
   localparam logic [CNT_W-1:0] LAST_LARGE = CNT_W'(LEN_LARGE - 1);

   burst_state_t      state;
   logic              mode_q;
   logic [CH_W-1:0]   ch_q;
   logic              busy_q;
   logic              done_q;
   logic              active;
   logic              beat;
   logic              at_last;
   logic              cnt_load;
   logic [CNT_W-1:0]  last;
   logic [CNT_W-1:0]  count;

   assign active   = (state == ST_WRITE) || (state == ST_HOLD);
   assign beat     = active && !stall && !abort;
   assign last     = mode_q ? LAST_LARGE : LAST_SMALL;
   // Counter sits at zero outside a burst and is cleared by the final beat.
   assign cnt_load = (state == ST_IDLE) || abort || (beat && at_last);

   burst_counter #(
      .CNT_W (CNT_W)
   ) u_counter (
      .clock   (clock),
      .reset   (reset),
      .load    (cnt_load),
      .enable  (beat),
      .last    (last),
      .count   (count),
      .at_last (at_last)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         mode_q <= 1'b0;
         ch_q   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else if (abort) begin
         state  <= ST_IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  mode_q <= mode;
                  ch_q   <= (int'(ch_sel) < NUM_CH) ? ch_sel : '0;
                  state  <= ST_WRITE;
                  busy_q <= 1'b1;
               end
            end
            ST_WRITE, ST_HOLD: begin
               if (stall) begin
                  state <= ST_HOLD;
               end else if (at_last) begin
                  state  <= ST_DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end else begin
                  state <= ST_WRITE;
               end
            end
            ST_DONE: begin
               state  <= ST_IDLE;
               done_q <= 1'b0;
            end
            default: begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      we = '0;
      if (beat)
         we[ch_q] = 1'b1;
   end

   assign addr = count;
   assign busy = busy_q;
   // An abort landing on the DONE cycle cancels the pulse.
   assign done = done_q && !abort;

`ifdef FIFO_BURST_CTRL_ERR_EN
   logic err_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         err_q <= 1'b0;
      else if (start && (state != ST_IDLE))
         err_q <= 1'b1;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_burst_ctrl.sv
// Self-checking bench for fifo_burst_ctrl against a beat-level reference model.
module tb_fifo_burst_ctrl;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 4;
   localparam int LEN_S  = 4;
   localparam int LEN_L  = 8;
`ifdef FIFO_BURST_CTRL_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic             clock   = 1'b0;
   logic             reset   = 1'b1;
   logic             start   = 1'b0;
   logic             mode    = 1'b0;
   logic             stall   = 1'b0;
   logic             abort   = 1'b0;
   logic [1:0]       ch_sel  = 2'd0;
   logic [1:0]       ch_sel3 = 2'd3;
   logic [3:0]       we;
   logic [2:0]       we3;
   logic [CNT_W-1:0] addr, addr3;
   logic             busy, done, err, busy3, done3, err3;

   int n_cmp = 0;
   int n_err = 0;
   int beats = 0;
   int dones = 0;

   // Reference model: phase 0 idle, 1 bursting (writing or held), 2 done.
   int m_phase = 0;
   int m_idx   = 0;
   int m_len   = LEN_S;
   int m_ch    = 0;
   bit m_err   = 1'b0;

   always #5 clock = ~clock;

   fifo_burst_ctrl #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .LEN_SMALL(LEN_S), .LEN_LARGE(LEN_L)
   ) u_dut (
      .clock(clock), .reset(reset), .start(start), .mode(mode), .ch_sel(ch_sel),
      .stall(stall), .abort(abort), .we(we), .addr(addr), .busy(busy),
      .done(done), .err(err)
   );

   // Three channels leave select value 3 out of range.
   fifo_burst_ctrl #(
      .NUM_CH(3), .CNT_W(CNT_W), .LEN_SMALL(LEN_S), .LEN_LARGE(LEN_L)
   ) u_dut3 (
      .clock(clock), .reset(reset), .start(start), .mode(mode), .ch_sel(ch_sel3),
      .stall(stall), .abort(abort), .we(we3), .addr(addr3), .busy(busy3),
      .done(done3), .err(err3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s @%0t observed=%0h expected=%0h", tag, $time, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_we"}, 32'(we), 0);
      check({tag, "_we3"}, 32'(we3), 0);
      check({tag, "_addr"}, 32'(addr), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_err"}, 32'(err), 0);
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_idx   = 0;
      m_ch    = 0;
      m_err   = 1'b0;
   endtask

   task automatic step(input bit s, input bit md, input int ch, input bit st, input bit ab);
      bit   bt;
      int   chv;
      int   old_phase;
      logic [3:0] e_we;
      @(negedge clock);
      start  = s;
      mode   = md;
      ch_sel = 2'(ch);
      stall  = st;
      abort  = ab;
      #1;
      chv  = ch & 3;
      bt   = (m_phase == 1) && !st && !ab;
      e_we = bt ? 4'(1 << m_ch) : 4'b0000;
      check("we", 32'(we), 32'(e_we));
      check("we3", 32'(we3), bt ? 32'd1 : 32'd0);
      check("addr", 32'(addr), (m_phase == 1) ? m_idx : 0);
      check("addr3", 32'(addr3), (m_phase == 1) ? m_idx : 0);
      check("busy", 32'(busy), 32'(m_phase == 1));
      check("busy3", 32'(busy3), 32'(m_phase == 1));
      check("done", 32'(done), 32'((m_phase == 2) && !ab));
      check("done3", 32'(done3), 32'((m_phase == 2) && !ab));
      check("err", 32'(err), 32'(ERR_EN && m_err));
      check("err3", 32'(err3), 32'(ERR_EN && m_err));
      if (we != 4'b0000) beats++;
      if (done) dones++;

      old_phase = m_phase;
      if (ab) begin
         m_phase = 0;
         m_idx   = 0;
      end else begin
         case (m_phase)
            0: if (s) begin
               m_phase = 1;
               m_idx   = 0;
               m_len   = md ? LEN_L : LEN_S;
               m_ch    = (chv < NUM_CH) ? chv : 0;
            end
            1: if (bt) begin
               if (m_idx == m_len - 1) begin
                  m_phase = 2;
                  m_idx   = 0;
               end else begin
                  m_idx++;
               end
            end
            default: m_phase = 0;
         endcase
      end
      if (s && old_phase != 0) m_err = 1'b1;
   endtask

   initial begin
      // Reset state
      #23;
      check_zero("reset");
      @(negedge clock);
      reset = 1'b0;

      // Small burst to channel 2, no stall
      beats = 0; dones = 0;
      step(1, 0, 2, 0, 0);
      repeat (6) step(0, 0, 0, 0, 0);
      check("small_beats", beats, LEN_S);
      check("small_dones", dones, 1);

      // Large burst to channel 1 with a two-cycle stall at addr 3
      beats = 0; dones = 0;
      step(1, 1, 1, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0);
      repeat (2) begin
         step(0, 0, 0, 1, 0);
         check("stall_addr_held", 32'(addr), 3);
      end
      repeat (7) step(0, 0, 0, 0, 0);
      check("large_beats", beats, LEN_L);
      check("large_dones", dones, 1);

      // Abort after two beats, then a clean burst
      beats = 0; dones = 0;
      step(1, 1, 0, 0, 0);
      repeat (2) step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
      check("abort_addr", 32'(addr), 0);
      check("abort_beats", beats, 2);
      check("abort_dones", dones, 0);
      beats = 0;
      step(1, 0, 3, 0, 0);
      repeat (6) step(0, 0, 0, 0, 0);
      check("post_abort_beats", beats, LEN_S);
      check("post_abort_dones", dones, 1);

      // Start held high across bursts
      beats = 0; dones = 0;
      repeat (12) step(1, 0, 1, 0, 0);
      repeat (4) step(0, 0, 0, 0, 0);
      check("held_start_beats", beats, 2 * LEN_S);
      check("held_start_dones", dones, 2);
      check("err_sticky", 32'(err), 32'(ERR_EN));

      // Randomized traffic
      repeat (400) begin
         step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
              $urandom_range(0, 1) == 0, $urandom_range(0, 19) == 0);
      end
      repeat (12) step(0, 0, 0, 0, 0);

      // Asynchronous reset mid-burst
      step(1, 1, 2, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0);
      #2;
      reset = 1'b1;
      #1;
      check_zero("async_reset");
      model_reset();
      @(negedge clock);
      reset = 1'b0;

      // Out-of-range select on the 3-channel instance maps to channel 0
      beats = 0; dones = 0;
      step(1, 0, 3, 0, 0);
      step(0, 0, 0, 0, 0);
      check("map_we3", 32'(we3), 32'd1);
      check("map_we", 32'(we), 32'h8);
      repeat (5) step(0, 0, 0, 0, 0);
      check("map_beats", beats, LEN_S);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
